data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder end of the per-thread LSU data-memory handshake. It accepts read and write requests from NUM_CHANNELS LSUs, each holding valid, address and data, and arbitrates among them round-robin.
- It serves one access at a time against an internal single-port data array, after a configurable latency.
- It answers each request with a one-cycle ready pulse, plus read data for reads.
- It sits between the cores' LSU arrays and data memory, and acts as the behavioural data memory in sim.

Parameters:
- NUM_CHANNELS, 4, number of LSU channels served (≥1).
- ADDR_BITS, 8, data address width; array depth is 2**ADDR_BITS words.
- DATA_BITS, 32, word width (matches data_t).
- MEM_LATENCY, 2, cycles from grant to ready (≥1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_read_valid  in  [NUM_CHANNELS]  per-channel read request.
- mem_read_address  in  [NUM_CHANNELS][ADDR_BITS]  per-channel read address.
- mem_read_ready  out  [NUM_CHANNELS]  per-channel read-complete pulse.
- mem_read_data  out  [NUM_CHANNELS][DATA_BITS]  per-channel read data.
- mem_write_valid  in  [NUM_CHANNELS]  per-channel write request.
- mem_write_address  in  [NUM_CHANNELS][ADDR_BITS]  per-channel write address.
- mem_write_data  in  [NUM_CHANNELS][DATA_BITS]  per-channel write data.
- mem_write_ready  out  [NUM_CHANNELS]  per-channel write-complete pulse.
- busy  out  1  high while an access is in flight (BUSY or RESPOND).

Behaviour:
- Reset (reset=0, asynchronous):
  - all ready bits 0; all mem_read_data 0; busy 0; state IDLE; round-robin pointer 0; latency counter 0.
  - Reset mid-access abandons the access with no array write. Array contents are not reset.
- Eligibility: channel i is eligible when (read_valid[i] & ~read_ready[i]) | (write_valid[i] & ~write_ready[i]).
  - This blocks re-grant during the cycle in which the LSU still holds valid while ready is high.
- State IDLE:
  - At an edge with any eligible channel, grant the first eligible channel searching from pointer upward, wrapping at NUM_CHANNELS-1 to 0.
  - If the granted channel has both read and write valid, the read wins; the write is served on a later grant.
  - Latch channel, op, address and write data. Set counter=MEM_LATENCY-1, busy=1, go to BUSY.
- State BUSY:
  - At each edge, if counter≠0, decrement.
  - If counter==0, perform the access.
  - Write: array[addr] <= data; write_ready[ch] <= 1.
  - Read: mem_read_data[ch] <= array[addr]; read_ready[ch] <= 1.
  - Go to RESPOND.
- State RESPOND:
  - At the next edge, clear the ready bit, set pointer=(ch+1) mod NUM_CHANNELS, busy=0, go to IDLE.
  - No grant is made on this edge.
- Timing:
  - Ready is high exactly one cycle.
  - Ready rises MEM_LATENCY edges after the granting edge.
  - Back-to-back throughput is one access per MEM_LATENCY+2 cycles.
- Request fields (address, write data) are captured at grant; later input changes do not affect the in-flight access.
- mem_read_data[ch] holds its value after the ready pulse until the next read served on that channel; other channels' read data is untouched.
- Valid deasserted before grant: the request is simply not served; no error.
- Valid deasserted mid-access: the access completes and ready still pulses.
- Accesses are strictly serialized in grant order, so read-after-write to the same address from any channels returns the written value.
- At most one ready bit (read or write, any channel) is high in any cycle.

Test Plan:
- Reset release, ch0 write addr 5 data 0xDEADBEEF (MEM_LATENCY=2) -> write_ready[0] high for 1 cycle, exactly 2 edges after the grant edge; busy high 3 cycles; then ch0 read addr 5 -> read_ready[0] pulse with mem_read_data[0]=0xDEADBEEF.
- All 4 channels assert read simultaneously (pointer=0), addresses 10..13 preloaded 100..103 -> served in order ch0,1,2,3, each gets its own value, pulses spaced MEM_LATENCY+2 cycles apart.
- ch2 served, then ch2 and ch0 both request -> ch0 is served first (pointer=3 wraps), then ch2.
- LSU model holds valid one cycle after ready (as the real LSU does) -> no second grant to that channel; exactly one ready pulse per request.
- ch1 write addr 7 =0x55, same edge ch3 read addr 7 -> ch1 is granted first, so ch3 reads 0x55; mem_read_data[1] stays unchanged.
- Reset asserted asynchronously mid-BUSY on a write to addr 9 (old value 0x11) -> ready and busy drop immediately; array[9] still 0x11 when read back after reset release.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// LSU <-> data-memory handshake bundle: per-channel read/write request,
// address, write data, and the responder's ready pulses and read data.
interface data_mem_responder_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 32
);
  logic [NUM_CHANNELS-1:0]                mem_read_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address;
  logic [NUM_CHANNELS-1:0]                mem_read_ready;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data;
  logic [NUM_CHANNELS-1:0]                mem_write_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data;
  logic [NUM_CHANNELS-1:0]                mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );
endinterface

// File: rtl/data_mem_responder.sv
// Round-robin responder for the LSU data-memory handshake: serves one access at a
// time against a single-port array and answers with a one-cycle ready pulse.
module data_mem_responder #(
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 32,
  parameter int MEM_LATENCY  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  output logic                 busy
);

  localparam int CH_BITS  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int CNT_BITS = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int DEPTH    = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESPOND
  } state_t;

  state_t                                 state, state_next;
  logic [CH_BITS-1:0]                     rr_ptr, cur_ch, grant_ch, search_ch;
  logic                                   cur_is_read, grant_is_read, grant_found;
  logic [ADDR_BITS-1:0]                   cur_addr;
  logic [DATA_BITS-1:0]                   cur_wdata;
  logic [CNT_BITS-1:0]                    lat_cnt;
  logic [NUM_CHANNELS-1:0]                rd_elig, eligible;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] read_data_q;
  logic                                   access_now, array_we;
  int                                     search_idx;

  logic [DATA_BITS-1:0] mem_array [DEPTH];

  // A channel whose ready is still high is ignored, so the LSU holding valid
  // for one more cycle cannot trigger a second grant.
  assign rd_elig       = bus.mem_read_valid & ~bus.mem_read_ready;
  assign eligible      = rd_elig | (bus.mem_write_valid & ~bus.mem_write_ready);
  assign grant_is_read = rd_elig[grant_ch];

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    search_idx  = 0;
    search_ch   = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      search_idx = int'(rr_ptr) + k;
      if (search_idx >= NUM_CHANNELS) search_idx = search_idx - NUM_CHANNELS;
      search_ch = CH_BITS'(search_idx);
      if (!grant_found && eligible[search_ch]) begin
        grant_found = 1'b1;
        grant_ch    = search_ch;
      end
    end
  end

  assign access_now = (state == S_BUSY) && (lat_cnt == '0);
  assign array_we   = access_now && !cur_is_read;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    if (grant_found) state_next = S_BUSY;
      S_BUSY:    if (lat_cnt == '0) state_next = S_RESPOND;
      S_RESPOND: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy                = 1'b0;
    bus.mem_read_ready  = '0;
    bus.mem_write_ready = '0;
    unique case (state)
      S_BUSY:    busy = 1'b1;
      S_RESPOND: begin
        busy = 1'b1;
        if (cur_is_read) bus.mem_read_ready[cur_ch]  = 1'b1;
        else             bus.mem_write_ready[cur_ch] = 1'b1;
      end
      default: ;
    endcase
  end

  // Request fields are captured at grant; later input changes do not reach the in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr      <= '0;
      cur_ch      <= '0;
      cur_is_read <= 1'b0;
      cur_addr    <= '0;
      cur_wdata   <= '0;
      lat_cnt     <= '0;
      read_data_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (grant_found) begin
          cur_ch      <= grant_ch;
          cur_is_read <= grant_is_read;
          cur_addr    <= grant_is_read ? bus.mem_read_address[grant_ch]
                                       : bus.mem_write_address[grant_ch];
          cur_wdata   <= bus.mem_write_data[grant_ch];
          lat_cnt     <= CNT_BITS'(MEM_LATENCY - 1);
        end
        S_BUSY: begin
          if (lat_cnt != '0)    lat_cnt <= lat_cnt - 1'b1;
          else if (cur_is_read) read_data_q[cur_ch] <= mem_array[cur_addr];
        end
        S_RESPOND:
          rr_ptr <= (cur_ch == CH_BITS'(NUM_CHANNELS - 1)) ? '0 : cur_ch + 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the array has no reset; a reset mid-access drops the state to IDLE, which kills the write enable.
  always_ff @(posedge clk) begin
    if (array_we) mem_array[cur_addr] <= cur_wdata;
  end

  assign bus.mem_read_data = read_data_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus random
// batches, checked against an in-bench memory / round-robin service model.
module tb_data_mem_responder;
  localparam int N    = 4;
  localparam int AB   = 8;
  localparam int DB   = 32;
  localparam int L    = 2;
  localparam int SPAN = L + 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic busy;

  data_mem_responder_if #(.NUM_CHANNELS(N), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  data_mem_responder #(
    .NUM_CHANNELS(N), .ADDR_BITS(AB), .DATA_BITS(DB), .MEM_LATENCY(L)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DB-1:0] ref_mem   [2**AB];
  logic [DB-1:0] ref_rdata [N];
  int            ref_ptr;

  bit            req_rd    [N];
  bit            req_wr    [N];
  logic [AB-1:0] req_raddr [N];
  logic [AB-1:0] req_waddr [N];
  logic [DB-1:0] req_wdata [N];

  int            exp_ch   [$];
  bit            exp_rd   [$];
  logic [DB-1:0] exp_data [$];

  task automatic clear_req();
    for (int i = 0; i < N; i++) begin
      req_rd[i] = 1'b0; req_wr[i] = 1'b0;
      req_raddr[i] = '0; req_waddr[i] = '0; req_wdata[i] = '0;
    end
  endtask

  task automatic drive_idle();
    bus.mem_read_valid    = '0;
    bus.mem_read_address  = '0;
    bus.mem_write_valid   = '0;
    bus.mem_write_address = '0;
    bus.mem_write_data    = '0;
  endtask

  // Service order from the rules: first pending channel at or after the pointer,
  // read before write on the same channel, pointer moves past the served channel.
  task automatic predict();
    bit prd [N];
    bit pwr [N];
    int ch;
    bit any;
    exp_ch.delete(); exp_rd.delete(); exp_data.delete();
    for (int i = 0; i < N; i++) begin prd[i] = req_rd[i]; pwr[i] = req_wr[i]; end
    do begin
      any = 1'b0; ch = 0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (ref_ptr + k) % N;
        if (!any && (prd[c] || pwr[c])) begin any = 1'b1; ch = c; end
      end
      if (any) begin
        exp_ch.push_back(ch);
        if (prd[ch]) begin
          exp_rd.push_back(1'b1);
          exp_data.push_back(ref_mem[req_raddr[ch]]);
          prd[ch] = 1'b0;
        end else begin
          exp_rd.push_back(1'b0);
          exp_data.push_back(req_wdata[ch]);
          ref_mem[req_waddr[ch]] = req_wdata[ch];
          pwr[ch] = 1'b0;
        end
        ref_ptr = (ch + 1) % N;
      end
    end while (any);
  endtask

  // Presents the request table at once; each LSU keeps valid up to the edge
  // after its ready pulse and drops it before the following one.
  task automatic run_batch(input string name);
    int            n, seen, ch;
    bit            drop_rd [N];
    bit            drop_wr [N];
    logic [N-1:0]  rr, wr, pulse;
    bit            exp_busy, is_rd;
    predict();
    n = exp_ch.size();
    seen = 0;
    for (int i = 0; i < N; i++) begin
      drop_rd[i] = 1'b0; drop_wr[i] = 1'b0;
      bus.mem_read_valid[i]    = req_rd[i];
      bus.mem_read_address[i]  = req_raddr[i];
      bus.mem_write_valid[i]   = req_wr[i];
      bus.mem_write_address[i] = req_waddr[i];
      bus.mem_write_data[i]    = req_wdata[i];
    end
    for (int t = 1; t <= n * SPAN + 1; t++) begin
      @(negedge clk);
      rr = bus.mem_read_ready;
      wr = bus.mem_write_ready;
      pulse = rr | wr;
      exp_busy = ((t - 1) / SPAN < n) && ((t - 1) % SPAN <= L);
      total++;
      if (busy !== exp_busy) begin
        bad++; $display("FAIL %s busy t=%0d got=%b want=%b", name, t, busy, exp_busy);
      end
      for (int i = 0; i < N; i++) begin
        if (drop_rd[i]) begin bus.mem_read_valid[i] = 1'b0; drop_rd[i] = 1'b0; end
        if (drop_wr[i]) begin bus.mem_write_valid[i] = 1'b0; drop_wr[i] = 1'b0; end
      end
      total++;
      if ($countones(rr) + $countones(wr) > 1) begin
        bad++; $display("FAIL %s onehot t=%0d rd_ready=%b wr_ready=%b want<=1 bit", name, t, rr, wr);
      end
      if (pulse != '0) begin
        ch = 0;
        for (int i = N - 1; i >= 0; i--) if (pulse[i]) ch = i;
        is_rd = rr[ch];
        if (seen < n) begin
          total++;
          if (ch != exp_ch[seen] || is_rd != exp_rd[seen]) begin
            bad++; $display("FAIL %s order #%0d got ch%0d rd=%0d want ch%0d rd=%0d",
                            name, seen, ch, is_rd, exp_ch[seen], exp_rd[seen]);
          end
          total++;
          if (t != 1 + seen * SPAN + L) begin
            bad++; $display("FAIL %s timing #%0d got t=%0d want t=%0d", name, seen, t, 1 + seen * SPAN + L);
          end
          if (is_rd) ref_rdata[ch] = exp_data[seen];
        end else begin
          total++; bad++;
          $display("FAIL %s extra pulse t=%0d ch%0d got pulse want none", name, t, ch);
        end
        for (int i = 0; i < N; i++) begin
          total++;
          if (bus.mem_read_data[i] !== ref_rdata[i]) begin
            bad++; $display("FAIL %s rdata[%0d] t=%0d got=%h want=%h", name, i, t, bus.mem_read_data[i], ref_rdata[i]);
          end
        end
        if (is_rd) drop_rd[ch] = 1'b1;
        else       drop_wr[ch] = 1'b1;
        seen++;
      end
    end
    total++;
    if (seen != n) begin
      bad++; $display("FAIL %s pulse_count got=%0d want=%0d", name, seen, n);
    end
    drive_idle();
    clear_req();
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b want=0", busy); end
    total++;
    if (bus.mem_read_ready !== '0 || bus.mem_write_ready !== '0) begin
      bad++; $display("FAIL reset ready got rd=%b wr=%b want 0", bus.mem_read_ready, bus.mem_write_ready);
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (bus.mem_read_data[i] !== '0) begin
        bad++; $display("FAIL reset rdata[%0d] got=%h want=0", i, bus.mem_read_data[i]);
      end
    end
    reset = 1'b1;
    ref_ptr = 0;
    for (int i = 0; i < N; i++) ref_rdata[i] = '0;
  endtask

  task automatic test_basic();
    clear_req();
    req_wr[0] = 1'b1; req_waddr[0] = 8'd5; req_wdata[0] = 32'hDEAD_BEEF;
    run_batch("basic_write");
    req_rd[0] = 1'b1; req_raddr[0] = 8'd5;
    run_batch("basic_read");
    total++;
    if (bus.mem_read_data[0] !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL basic_value got=%h want=deadbeef", bus.mem_read_data[0]);
    end
  endtask

  task automatic test_all_read();
    clear_req();
    for (int i = 0; i < N; i++) begin
      req_wr[i] = 1'b1; req_waddr[i] = AB'(10 + i); req_wdata[i] = DB'(100 + i);
    end
    run_batch("preload");
    for (int i = 0; i < N; i++) begin req_rd[i] = 1'b1; req_raddr[i] = AB'(10 + i); end
    run_batch("all_read");
    for (int i = 0; i < N; i++) begin
      total++;
      if (bus.mem_read_data[i] !== DB'(100 + i)) begin
        bad++; $display("FAIL all_read_value[%0d] got=%0d want=%0d", i, bus.mem_read_data[i], 100 + i);
      end
    end
  endtask

  task automatic test_raw();
    clear_req();
    req_wr[1] = 1'b1; req_waddr[1] = 8'd7; req_wdata[1] = 32'h55;
    req_rd[3] = 1'b1; req_raddr[3] = 8'd7;
    run_batch("raw");
    total++;
    if (bus.mem_read_data[3] !== 32'h55) begin
      bad++; $display("FAIL raw_value got=%h want=55", bus.mem_read_data[3]);
    end
    total++;
    if (bus.mem_read_data[1] !== 32'd101) begin
      bad++; $display("FAIL raw_untouched got=%0d want=101", bus.mem_read_data[1]);
    end
  endtask

  task automatic test_wrap();
    clear_req();
    req_rd[2] = 1'b1; req_raddr[2] = 8'd10;
    run_batch("wrap_first");
    req_rd[2] = 1'b1; req_raddr[2] = 8'd12;
    req_rd[0] = 1'b1; req_raddr[0] = 8'd11;
    run_batch("wrap_pair");
    total++;
    if (bus.mem_read_data[0] !== 32'd101 || bus.mem_read_data[2] !== 32'd102) begin
      bad++; $display("FAIL wrap_values got ch0=%0d ch2=%0d want 101 102", bus.mem_read_data[0], bus.mem_read_data[2]);
    end
  endtask

  // Inputs change right after the grant and valid drops mid-access; a request
  // raised and withdrawn while busy must never be served.
  task automatic test_capture();
    int wr_at;
    bit rd1_seen;
    @(negedge clk);
    drive_idle();
    bus.mem_write_valid[0]   = 1'b1;
    bus.mem_write_address[0] = 8'd20;
    bus.mem_write_data[0]    = 32'hA5A5_0001;
    ref_mem[20] = 32'hA5A5_0001;
    ref_ptr = 1;
    @(negedge clk);
    bus.mem_write_address[0] = 8'd21;
    bus.mem_write_data[0]    = 32'h0000_0BAD;
    bus.mem_write_valid[0]   = 1'b0;
    bus.mem_read_valid[1]    = 1'b1;
    bus.mem_read_address[1]  = 8'd20;
    wr_at = -1; rd1_seen = 1'b0;
    for (int t = 2; t <= 8; t++) begin
      @(negedge clk);
      if (bus.mem_write_ready[0] === 1'b1) wr_at = t;
      if (bus.mem_read_ready[1] === 1'b1) rd1_seen = 1'b1;
      if (t == 2) bus.mem_read_valid[1] = 1'b0;
    end
    total++;
    if (wr_at != 1 + L) begin bad++; $display("FAIL capture_ready got t=%0d want t=%0d", wr_at, 1 + L); end
    total++;
    if (rd1_seen) begin bad++; $display("FAIL withdrawn_request got pulse=1 want 0"); end
    drive_idle();
    clear_req();
    req_rd[0] = 1'b1; req_raddr[0] = 8'd20;
    run_batch("capture_readback");
    total++;
    if (bus.mem_read_data[0] !== 32'hA5A5_0001) begin
      bad++; $display("FAIL capture_value got=%h want=a5a50001", bus.mem_read_data[0]);
    end
  endtask

  task automatic test_async_reset();
    clear_req();
    req_wr[0] = 1'b1; req_waddr[0] = 8'd9; req_wdata[0] = 32'h11;
    run_batch("reset_preload");
    bus.mem_write_valid[2]   = 1'b1;
    bus.mem_write_address[2] = 8'd9;
    bus.mem_write_data[2]    = 32'h99;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL async_reset busy got=%b want=0", busy); end
    total++;
    if (bus.mem_read_ready !== '0 || bus.mem_write_ready !== '0) begin
      bad++; $display("FAIL async_reset ready got rd=%b wr=%b want 0", bus.mem_read_ready, bus.mem_write_ready);
    end
    total++;
    if (bus.mem_read_data !== '0) begin
      bad++; $display("FAIL async_reset rdata got=%h want 0", bus.mem_read_data);
    end
    drive_idle();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ref_ptr = 0;
    for (int i = 0; i < N; i++) ref_rdata[i] = '0;
    req_rd[1] = 1'b1; req_raddr[1] = 8'd9;
    run_batch("reset_readback");
    total++;
    if (bus.mem_read_data[1] !== 32'h11) begin
      bad++; $display("FAIL reset_no_write got=%h want=11", bus.mem_read_data[1]);
    end
  endtask

  task automatic test_random();
    for (int b = 0; b < 4; b++) begin
      clear_req();
      for (int i = 0; i < N; i++) begin
        req_wr[i] = 1'b1; req_waddr[i] = AB'(b * N + i); req_wdata[i] = $urandom;
      end
      run_batch("rand_init");
    end
    for (int b = 0; b < 25; b++) begin
      clear_req();
      for (int i = 0; i < N; i++) begin
        req_rd[i]    = bit'($urandom_range(0, 1));
        req_wr[i]    = bit'($urandom_range(0, 1));
        req_raddr[i] = AB'($urandom_range(0, 15));
        req_waddr[i] = AB'($urandom_range(0, 15));
        req_wdata[i] = $urandom;
      end
      run_batch("rand_batch");
    end
  endtask

  initial begin
    clear_req();
    test_reset();
    @(negedge clk);
    test_basic();
    test_all_read();
    test_raw();
    test_wrap();
    test_capture();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
